// File: rtl/memory_rr_scheduler.sv
// rtl/memory_rr_scheduler.sv - round-robin scheduler sharing one memory bus among N requesters
//
// Purpose: arbitrates NUM_PORTS request ports (icache, dcache, debug/DMA, ...) onto a
// single memory bus with one outstanding transaction, rotating priority, a registered
// one-hot grant and a lock that lets a port keep the bus for its next request.
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   req_valid_i/write/lock   per-port request controls (one bit per port)
//   req_addr_i/req_wr_data_i per-port fields, port i at [i*W +: W]
//   req_ready_o              one-cycle completion pulse to the granted port
//   req_rd_data_o            memory read data, valid with req_ready_o
//   grant_o, busy_o          registered one-hot grant, scheduler not idle
//   mem_*                    memory-side request / response handshake

module memory_rr_scheduler #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS-1:0]        req_write_i,
  input  logic [NUM_PORTS-1:0]        req_lock_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wr_data_i,
  output logic [NUM_PORTS-1:0]        req_ready_o,
  output logic [DATA_W-1:0]           req_rd_data_o,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        busy_o,
  output logic                        mem_valid_o,
  output logic                        mem_write_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wr_data_o,
  input  logic                        mem_ready_i,
  input  logic [DATA_W-1:0]           mem_rd_data_i
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT} state_t;

  state_t          state;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   last_q;
  logic            lock_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;

  logic            sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Winner search: a locked owner that is still requesting wins outright; otherwise
  // scan last_q+1 .. last_q+NUM_PORTS with an explicit wrap so a non-power-of-2
  // port count can never produce an out-of-range index.
  always_comb begin
    int          cand;
    logic [IW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (lock_q && req_valid_i[last_q]) begin
      win_found = 1'b1;
      win_idx   = last_q;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = int'(last_q) + k;
        if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
        cand_idx = IW'(cand);
        if (!win_found && req_valid_i[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      lock_q  <= 1'b0;
      grant_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ready_i) begin
            // Arbitration always consumes the lock: either the owner wins again
            // or it was not requesting and the lock lapses.
            lock_q <= 1'b0;
            if (win_found) begin
              grant_q <= win_idx;
              last_q  <= win_idx;
              grant_o <= onehot(win_idx);
              state   <= REQUEST;
            end
          end
        end
        REQUEST: begin
          if (!mem_ready_i) state <= WAIT;
        end
        WAIT: begin
          if (mem_ready_i) begin
            lock_q  <= req_lock_i[grant_q];
            grant_o <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IW'(i)) begin
        sel_write = req_write_i[i];
        sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wr_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Memory-side fields are forced to zero while idle so reset clears every output.
  assign busy_o        = (state != IDLE);
  assign mem_valid_o   = (state == REQUEST);
  assign mem_write_o   = busy_o & sel_write;
  assign mem_addr_o    = busy_o ? sel_addr  : '0;
  assign mem_wr_data_o = busy_o ? sel_wdata : '0;
  assign req_ready_o   = (state == WAIT && mem_ready_i) ? grant_o : '0;
  assign req_rd_data_o = (state == WAIT) ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_memory_rr_scheduler.sv
// tb/tb_memory_rr_scheduler.sv - directed scoreboard bench for memory_rr_scheduler

module tb_memory_rr_scheduler;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset_ni;
  logic [NP-1:0]     req_valid_i, req_write_i, req_lock_i;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP*DW-1:0]  req_wr_data_i;
  logic [NP-1:0]     req_ready_o;
  logic [DW-1:0]     req_rd_data_o;
  logic [NP-1:0]     grant_o;
  logic              busy_o, mem_valid_o, mem_write_o;
  logic [AW-1:0]     mem_addr_o;
  logic [DW-1:0]     mem_wr_data_o;
  logic              mem_ready_i;
  logic [DW-1:0]     mem_rd_data_i;

  memory_rr_scheduler #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_lock_i(req_lock_i),
    .req_addr_i(req_addr_i), .req_wr_data_i(req_wr_data_i),
    .req_ready_o(req_ready_o), .req_rd_data_o(req_rd_data_o),
    .grant_o(grant_o), .busy_o(busy_o),
    .mem_valid_o(mem_valid_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_ready_i(mem_ready_i), .mem_rd_data_i(mem_rd_data_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        write;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int   port;
    txn_t t;
  } exp_t;

  txn_t tbl [NP][4];
  int   ntx [NP];
  int   idx [NP];
  bit   adv [NP];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  bit          mem_busy = 1'b0;
  bit          accept_seen = 1'b0;
  int          cnt = 0;
  int          busy_cycles = 3;
  logic [31:0] acc_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  function automatic logic [NP-1:0] oh(input int p);
    return NP'(1) << p;
  endfunction

  task automatic add_txn(input int p, input logic w, input logic lk,
                         input logic [31:0] a, input logic [31:0] d);
    tbl[p][ntx[p]] = '{w, lk, a, d};
    ntx[p]++;
  endtask

  task automatic expect_txn(input int p, input int k);
    exp_q.push_back('{p, tbl[p][k]});
  endtask

  task automatic drive_port(input int p);
    if (idx[p] < ntx[p]) begin
      req_valid_i[p]              = 1'b1;
      req_write_i[p]              = tbl[p][idx[p]].write;
      req_lock_i[p]               = tbl[p][idx[p]].lock;
      req_addr_i[p*AW +: AW]      = tbl[p][idx[p]].addr;
      req_wr_data_i[p*DW +: DW]   = tbl[p][idx[p]].wdata;
    end else begin
      req_valid_i[p] = 1'b0;
    end
  endtask

  // One clock of the environment: port sequencing, memory responder and scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (adv[p]) begin
        adv[p] = 1'b0;
        idx[p]++;
        drive_port(p);
      end
    end
    if (grant_o != '0)
      chk("grant_held_valid", 64'(grant_o & req_valid_i), 64'(grant_o));
    if (accept_seen) begin
      mem_ready_i = 1'b0;
      cnt         = busy_cycles - 1;
      mem_busy    = 1'b1;
      accept_seen = 1'b0;
    end else if (mem_busy) begin
      if (cnt > 0) cnt--;
      else begin
        mem_ready_i   = 1'b1;
        mem_rd_data_i = rd_model(acc_addr);
        mem_busy      = 1'b0;
      end
    end
    #1;
    if (req_ready_o != '0) begin
      for (int p = 0; p < NP; p++) if (req_ready_o[p]) adv[p] = 1'b1;
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_cpl", 64'(req_ready_o), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("cpl_ready", 64'(req_ready_o), 64'(oh(e.port)));
        chk("cpl_rdata", 64'(req_rd_data_o), 64'(rd_model(e.t.addr)));
      end
    end
    if (mem_valid_o && mem_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_accept", 64'(grant_o), 64'd0);
      else begin
        e = exp_q[0];
        chk("acc_grant", 64'(grant_o), 64'(oh(e.port)));
        chk("acc_addr", 64'(mem_addr_o), 64'(e.t.addr));
        chk("acc_write", 64'(mem_write_o), 64'(e.t.write));
        chk("acc_wdata", 64'(mem_wr_data_o), 64'(e.t.wdata));
      end
      accept_seen = 1'b1;
      acc_addr    = mem_addr_o;
    end
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 400 && n_done < target; c++) tick();
    chk("done_count", 64'(n_done), 64'(target));
  endtask

  task automatic clear_env();
    req_valid_i = '0;
    mem_ready_i = 1'b1;
    mem_busy    = 1'b0;
    accept_seen = 1'b0;
    cnt         = 0;
    n_done      = 0;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      ntx[p] = 0;
      idx[p] = 0;
      adv[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ni = 1'b0;
    clear_env();
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
  endtask

  initial begin
    reset_ni      = 1'b0;
    req_valid_i   = '0;
    req_write_i   = '0;
    req_lock_i    = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    mem_ready_i   = 1'b1;
    mem_rd_data_i = '0;

    // Single read from port 1, 3-cycle memory
    do_reset();
    chk("rst_outputs", 64'({grant_o, req_ready_o, busy_o, mem_valid_o}), 64'd0);
    add_txn(1, 1'b0, 1'b0, 32'h100, 32'h0);
    expect_txn(1, 0);
    drive_port(1);
    tick();
    chk("t1_mem_valid", 64'(mem_valid_o), 64'd1);
    chk("t1_grant", 64'(grant_o), 64'(3'b010));
    wait_done(1);
    tick();
    chk("t1_grant_clear", 64'(grant_o), 64'd0);
    chk("t1_busy_clear", 64'(busy_o), 64'd0);

    // All ports requesting: rotation 0,1,2,0,1,2
    do_reset();
    busy_cycles = 2;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 2; k++)
        add_txn(p, 1'((p + k) % 2), 1'b0, 32'h1000 + 32'(p*16 + k*4), 32'hA000 + 32'(p*16 + k));
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) expect_txn(p, k);
    for (int p = 0; p < NP; p++) drive_port(p);
    wait_done(6);

    // Lock: port 2 read-modify-write keeps the bus while port 0 waits
    do_reset();
    busy_cycles = 1;
    add_txn(2, 1'b0, 1'b1, 32'h40, 32'h0);
    add_txn(2, 1'b1, 1'b0, 32'h40, 32'h5555AAAA);
    expect_txn(2, 0);
    expect_txn(2, 1);
    drive_port(2);
    tick();
    add_txn(0, 1'b0, 1'b0, 32'h80, 32'h0);
    expect_txn(0, 0);
    drive_port(0);
    wait_done(1);
    tick();
    chk("t3_lock_set", 64'(dut.lock_q), 64'd1);
    wait_done(2);
    tick();
    chk("t3_lock_clear", 64'(dut.lock_q), 64'd0);
    wait_done(3);

    // Lock owner drops valid: lock lapses, port 0 served
    do_reset();
    add_txn(1, 1'b1, 1'b1, 32'h200, 32'h1111);
    expect_txn(1, 0);
    drive_port(1);
    tick();
    add_txn(0, 1'b0, 1'b0, 32'h300, 32'h0);
    expect_txn(0, 0);
    drive_port(0);
    wait_done(1);
    tick();
    chk("t4_lock_set", 64'(dut.lock_q), 64'd1);
    tick();
    chk("t4_lock_lapsed", 64'(dut.lock_q), 64'd0);
    chk("t4_grant_p0", 64'(grant_o), 64'(3'b001));
    wait_done(2);

    // Memory not ready in IDLE: no arbitration until it returns
    do_reset();
    mem_ready_i = 1'b0;
    add_txn(0, 1'b0, 1'b0, 32'h500, 32'h0);
    expect_txn(0, 0);
    drive_port(0);
    repeat (3) begin
      tick();
      chk("t5_no_valid", 64'(mem_valid_o), 64'd0);
      chk("t5_not_busy", 64'(busy_o), 64'd0);
    end
    mem_ready_i = 1'b1;
    tick();
    chk("t5_valid_after_release", 64'(mem_valid_o), 64'd1);
    chk("t5_grant_p0", 64'(grant_o), 64'(3'b001));
    wait_done(1);

    // Asynchronous reset in WAIT of port 1
    do_reset();
    busy_cycles = 5;
    mem_rd_data_i = 32'hFFFFFFFF;
    add_txn(1, 1'b1, 1'b0, 32'h600, 32'h77);
    expect_txn(1, 0);
    drive_port(1);
    for (int c = 0; c < 20 && !(busy_o && !mem_valid_o); c++) tick();
    chk("t6_in_wait", 64'({busy_o, mem_valid_o}), 64'(2'b10));
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t6_ctrl_zero", 64'({req_ready_o, grant_o, busy_o, mem_valid_o, mem_write_o}), 64'd0);
    chk("t6_addr_zero", 64'(mem_addr_o), 64'd0);
    chk("t6_wdata_zero", 64'(mem_wr_data_o), 64'd0);
    chk("t6_rdata_zero", 64'(req_rd_data_o), 64'd0);
    mem_ready_i = 1'b1;
    mem_busy    = 1'b0;
    accept_seen = 1'b0;
    n_done      = 0;
    exp_q.delete();
    busy_cycles = 2;
    repeat (2) @(negedge clk);
    add_txn(0, 1'b0, 1'b0, 32'h700, 32'h0);
    expect_txn(0, 0);
    expect_txn(1, 0);
    drive_port(0);
    reset_ni = 1'b1;
    wait_done(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
